// File: rtl/tag_match_array_pkg.sv
// tag_match_array_pkg: shared geometry of the lease-cache tag store
package tag_match_array_pkg;
  localparam int N_ENTRIES = 1024;
  localparam int TAG_W = 22;
  localparam int IDX_W = $clog2(N_ENTRIES);
endpackage

// File: rtl/tag_match_array_entry.sv
// tag_match_entry: one tag/valid pair with local update decode and equality compare
module tag_match_entry
  import tag_match_array_pkg::*;
#(
  parameter int TW = TAG_W,
  parameter int IW = IDX_W,
  parameter int ID = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fill_en,
  input  logic [IW-1:0] fill_idx,
  input  logic [TW-1:0] fill_tag,
  input  logic          inv_en,
  input  logic [IW-1:0] inv_idx,
  input  logic          flush,
  input  logic [TW-1:0] cmp_tag,
  output logic          hit
);
  logic [TW-1:0] tag;
  logic valid;
  logic fill_sel, inv_sel;
  assign fill_sel = fill_en && fill_idx == IW'(ID);
  assign inv_sel = inv_en && inv_idx == IW'(ID);
  assign hit = valid && tag == cmp_tag;
  // the tag is written even when flush/inv/rst win the valid bit
  always_ff @(posedge clk) begin
    if (fill_sel) tag <= fill_tag;
    if (rst || flush || inv_sel) valid <= 1'b0;
    else if (fill_sel) valid <= 1'b1;
  end
endmodule

// File: rtl/tag_match_array.sv
// tag_match_array: fully-associative tag store producing a registered one-hot hit vector
module tag_match_array
  import tag_match_array_pkg::*;
#(
  parameter int N = N_ENTRIES,
  parameter int TW = TAG_W,
  parameter int IW = IDX_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [TW-1:0] req_tag,
  input  logic          fill_en,
  input  logic [IW-1:0] fill_idx,
  input  logic [TW-1:0] fill_tag,
  input  logic          inv_en,
  input  logic [IW-1:0] inv_idx,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  match_oht,
  output logic [TW-1:0] out_tag,
  output logic          multi_hit
);
  localparam logic [N-1:0] ONE = N'(1);
  logic [N-1:0] hits;
  logic acc, multi_nxt;
  for (genvar i = 0; i < N; i++) begin : g_entry
    tag_match_entry #(.TW(TW), .IW(IW), .ID(i)) u_entry (
      .clk(clk), .rst(rst),
      .fill_en(fill_en), .fill_idx(fill_idx), .fill_tag(fill_tag),
      .inv_en(inv_en), .inv_idx(inv_idx), .flush(flush),
      .cmp_tag(req_tag), .hit(hits[i])
    );
  end
  always_comb begin
    req_ready = !out_valid || out_ready;
    acc = req_valid && req_ready;
    multi_nxt = |(hits & (hits - ONE));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      match_oht <= '0;
      out_tag <= '0;
      multi_hit <= 1'b0;
    end else if (acc) begin
      out_valid <= 1'b1;
      match_oht <= hits;
      out_tag <= req_tag;
      multi_hit <= multi_nxt;
    end else if (out_ready) out_valid <= 1'b0;
  end
endmodule

// File: tb/tb_tag_match_array.sv
// tb_tag_match_array: table, hand-written and random checks against an array-based model
module tb_tag_match_array;
  import tag_match_array_pkg::*;
  localparam int N = N_ENTRIES;
  logic clk = 0, rst = 1;
  logic req_valid = 0, req_ready, fill_en = 0, inv_en = 0, flush = 0, out_valid, out_ready = 1, multi_hit;
  logic [TAG_W-1:0] req_tag = 0, fill_tag = 0, out_tag;
  logic [IDX_W-1:0] fill_idx = 0, inv_idx = 0;
  logic [N-1:0] match_oht;
  int total = 0, bad = 0;
  bit m_valid [N];
  logic [TAG_W-1:0] m_tag [N];
  bit e_ov = 0, e_multi = 0;
  logic [N-1:0] e_oht = '0;
  logic [TAG_W-1:0] e_tag = '0;

  tag_match_array dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_tag(req_tag),
    .fill_en(fill_en), .fill_idx(fill_idx), .fill_tag(fill_tag),
    .inv_en(inv_en), .inv_idx(inv_idx), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .match_oht(match_oht),
    .out_tag(out_tag), .multi_hit(multi_hit)
  );

  always #5 clk = ~clk;

  function automatic int lowest(logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic chk(string n, logic [63:0] a, logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", n, a, e, $time);
    end
  endtask

  task automatic chk_oht(string n, logic [N-1:0] a, logic [N-1:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s act_cnt=%0d exp_cnt=%0d act_low=%0d exp_low=%0d first_diff=%0d t=%0t",
               n, $countones(a), $countones(e), lowest(a), lowest(e), lowest(a ^ e), $time);
    end
  endtask

  // one clock: predict from the model, advance, update the model, compare all outputs
  task automatic cycle();
    bit acc, rdy;
    logic [N-1:0] h;
    #1;
    rdy = !e_ov || out_ready;
    chk("req_ready", req_ready, rdy);
    acc = req_valid && rdy;
    h = '0;
    for (int i = 0; i < N; i++) h[i] = m_valid[i] && m_tag[i] == req_tag;
    @(posedge clk);
    #1;
    if (rst) begin
      e_ov = 0; e_oht = '0; e_tag = '0; e_multi = 0;
    end else if (acc) begin
      e_ov = 1; e_oht = h; e_tag = req_tag; e_multi = $countones(h) > 1;
    end else if (out_ready) e_ov = 0;
    if (fill_en) m_tag[fill_idx] = fill_tag;
    if (rst || flush) begin
      for (int i = 0; i < N; i++) m_valid[i] = 0;
    end else begin
      if (fill_en) m_valid[fill_idx] = 1;
      if (inv_en) m_valid[inv_idx] = 0;
    end
    chk("out_valid", out_valid, e_ov);
    chk_oht("match_oht", match_oht, e_oht);
    chk("out_tag", out_tag, e_tag);
    chk("multi_hit", multi_hit, e_multi);
  endtask

  task automatic idle();
    req_valid = 0; fill_en = 0; inv_en = 0; flush = 0; rst = 0;
  endtask

  typedef struct {
    bit fe; int fi; int ft; bit ie; int ii; bit fl; int rt; int ec; int el;
  } vec_t;
  vec_t tbl [16];

  initial begin
    logic [N-1:0] snap, one5;
    logic [TAG_W-1:0] snap_tag;
    tbl[0]  = '{0, 0, 0, 0, 0, 0, 'h0, 0, -1};
    tbl[1]  = '{1, 5, 'h1234, 0, 0, 0, 'h1234, 0, -1};
    tbl[2]  = '{0, 0, 0, 0, 0, 0, 'h1234, 1, 5};
    tbl[3]  = '{1, 7, 'hAB, 0, 0, 0, 'hAB, 0, -1};
    tbl[4]  = '{0, 0, 0, 0, 0, 0, 'hAB, 1, 7};
    tbl[5]  = '{1, 3, 'h55, 0, 0, 0, 'h55, 0, -1};
    tbl[6]  = '{1, 900, 'h55, 0, 0, 0, 'h55, 1, 3};
    tbl[7]  = '{0, 0, 0, 0, 0, 0, 'h55, 2, 3};
    tbl[8]  = '{1, 3, 'h55, 1, 3, 0, 'h55, 2, 3};
    tbl[9]  = '{0, 0, 0, 0, 0, 0, 'h55, 1, 900};
    tbl[10] = '{1, 900, 'h66, 1, 7, 0, 'hAB, 1, 7};
    tbl[11] = '{0, 0, 0, 0, 0, 0, 'h66, 1, 900};
    tbl[12] = '{0, 0, 0, 0, 0, 0, 'hAB, 0, -1};
    tbl[13] = '{1, 2, 'h77, 0, 0, 1, 'h1234, 1, 5};
    tbl[14] = '{0, 0, 0, 0, 0, 0, 'h77, 0, -1};
    tbl[15] = '{0, 0, 0, 0, 0, 0, 'h1234, 0, -1};
    one5 = '0;
    one5[5] = 1'b1;
    @(posedge clk);
    cycle();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_multi", multi_hit, 0);
    idle();
    out_ready = 1;
    foreach (tbl[k]) begin
      fill_en = tbl[k].fe; fill_idx = IDX_W'(tbl[k].fi); fill_tag = TAG_W'(tbl[k].ft);
      inv_en = tbl[k].ie; inv_idx = IDX_W'(tbl[k].ii); flush = tbl[k].fl;
      req_valid = 1; req_tag = TAG_W'(tbl[k].rt);
      cycle();
      chk($sformatf("tbl%0d_cnt", k), $countones(match_oht), tbl[k].ec);
      chk($sformatf("tbl%0d_low", k), 64'(lowest(match_oht)), 64'(tbl[k].el));
      chk($sformatf("tbl%0d_multi", k), multi_hit, tbl[k].ec > 1);
    end
    // backpressure: held result is a snapshot even while entry 5 is invalidated
    idle();
    fill_en = 1; fill_idx = 5; fill_tag = 'h1234;
    cycle();
    idle();
    req_valid = 1; req_tag = 'h1234;
    cycle();
    chk_oht("bp_first", match_oht, one5);
    snap = match_oht;
    snap_tag = out_tag;
    out_ready = 0; req_tag = 'h99; inv_en = 1; inv_idx = 5;
    for (int c = 0; c < 4; c++) begin
      cycle();
      chk("bp_ready", req_ready, 0);
      chk_oht("bp_hold", match_oht, snap);
      chk("bp_tag", out_tag, snap_tag);
      inv_en = 0;
    end
    out_ready = 1; req_tag = 'h1234;
    cycle();
    chk("bp_release_cnt", $countones(match_oht), 0);
    chk("bp_release_tag", out_tag, 'h1234);
    // flush with same-index inv and fill, then everything misses
    idle();
    for (int i = 0; i < 8; i++) begin
      fill_en = 1; fill_idx = IDX_W'(i * 100); fill_tag = TAG_W'(i + 'h300);
      cycle();
    end
    idle();
    flush = 1; inv_en = 1; inv_idx = 2; fill_en = 1; fill_idx = 2; fill_tag = 'h300;
    cycle();
    idle();
    req_valid = 1;
    for (int i = 0; i < 8; i++) begin
      req_tag = TAG_W'(i + 'h300);
      cycle();
      chk("flush_miss", $countones(match_oht), 0);
    end
    // reset drops a result held under backpressure
    out_ready = 0;
    cycle();
    chk("pend_valid", out_valid, 1);
    rst = 1;
    cycle();
    chk("rst_drop_valid", out_valid, 0);
    chk("rst_drop_tag", out_tag, 0);
    idle();
    out_ready = 1;
    for (int c = 0; c < 400; c++) begin
      rst = $urandom_range(0, 149) == 0;
      flush = $urandom_range(0, 49) == 0;
      req_valid = $urandom_range(0, 3) != 0;
      req_tag = TAG_W'($urandom_range(0, 5));
      out_ready = $urandom_range(0, 3) != 0;
      fill_en = $urandom_range(0, 1) == 1;
      fill_idx = $urandom_range(0, 1) ? IDX_W'($urandom_range(0, 15)) : IDX_W'($urandom_range(1008, 1023));
      fill_tag = TAG_W'($urandom_range(0, 5));
      inv_en = $urandom_range(0, 3) == 0;
      inv_idx = $urandom_range(0, 1) ? IDX_W'($urandom_range(0, 15)) : fill_idx;
      cycle();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
